// File: rtl/f1_pkg.sv
// Shared types and defaults for the F1 start-lights sequencer.
// Holds the controller state enum and default bank/random widths.
package f1_pkg;
  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } f1_state_t;

  localparam int NLIGHTS_D = 8;
  localparam int RW_D      = 7;
endpackage

// File: rtl/delay_counter.sv
// Loadable RW-bit down-counter timing the all-lights-on hold.
// Ports: clk, rst, load/load_val, dec, clr -> count, last (count == 1).
module delay_counter #(
  parameter int RW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [RW-1:0] load_val,
  input  logic          dec,
  input  logic          clr,
  output logic [RW-1:0] count,
  output logic          last
);

  localparam logic [RW-1:0] ONE = RW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - ONE;
    end
  end

  assign last = (count == ONE);

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start-lights sequencer: fills lights per tick, holds a random delay, pulses done.
// Ports: trigger/abort/tick/rnd in; lfsr_en, lights, delay_q, busy, done out.
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int NLIGHTS   = NLIGHTS_D,
  parameter int RW        = RW_D,
  parameter int MIN_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trigger,
  input  logic               abort,
  input  logic               tick,
  input  logic [RW-1:0]      rnd,
  output logic               lfsr_en,
  output logic [NLIGHTS-1:0] lights,
  output logic [RW-1:0]      delay_q,
  output logic               busy,
  output logic               done
);

  localparam logic [RW-1:0] MIN_V = RW'(MIN_DELAY);

  f1_state_t state, state_n;
  logic [NLIGHTS-1:0] lights_n;
  logic [RW-1:0] delay_n;
  logic [RW-1:0] cap;
  logic [RW-1:0] cnt;
  logic done_n;
  logic c_load;
  logic c_dec;
  logic c_clr;
  logic c_last;

  assign cap = (rnd < MIN_V) ? MIN_V : rnd;

  delay_counter #(
    .RW(RW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (c_load),
    .load_val (cap),
    .dec      (c_dec),
    .clr      (c_clr),
    .count    (cnt),
    .last     (c_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lights  <= '0;
      delay_q <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      lights  <= lights_n;
      delay_q <= delay_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    lights_n = lights;
    delay_n  = delay_q;
    done_n   = 1'b0;
    c_load   = 1'b0;
    c_dec    = 1'b0;
    c_clr    = 1'b0;
    if (abort) begin
      state_n  = IDLE;
      lights_n = '0;
      c_clr    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          lights_n = '0;
          if (trigger) state_n = FILL;
        end
        FILL: begin
          if (tick) begin
            if (lights != '1) begin
              lights_n = {lights[NLIGHTS-2:0], 1'b1};
            end else begin
              delay_n = cap;
              c_load  = 1'b1;
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (c_last) begin
              lights_n = '0;
              done_n   = 1'b1;
              state_n  = IDLE;
            end else begin
              // zero guard keeps the counter from wrapping
              c_dec = (cnt != '0);
            end
          end
        end
        default: begin
          state_n  = IDLE;
          lights_n = '0;
        end
      endcase
    end
  end

  // random source runs until the hold length is committed
  assign lfsr_en = (state != HOLD);
  assign busy    = (state == FILL) || (state == HOLD);

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Scoreboard bench for f1_start_ctrl: driver queues expected output snapshots,
// monitor pops one per observed change of {lights, delay_q, done}.
module tb_f1_start_ctrl;

  logic       clk;
  logic       rst;
  logic       trigger;
  logic       abort;
  logic       tick;
  logic [6:0] rnd;
  logic       lfsr_en;
  logic [7:0] lights;
  logic [6:0] delay_q;
  logic       busy;
  logic       done;

  f1_start_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .trigger (trigger),
    .abort   (abort),
    .tick    (tick),
    .rnd     (rnd),
    .lfsr_en (lfsr_en),
    .lights  (lights),
    .delay_q (delay_q),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] l;
    logic [6:0] d;
    logic       dn;
  } snap_t;

  snap_t exp_q[$];
  snap_t prev;
  snap_t cur_s;
  snap_t exp_s;
  int checks = 0;
  int failures = 0;
  bit mon_en = 0;
  bit hold_trig = 0;
  bit trig_rand = 0;
  bit gap_fixed = 0;
  int ph = 0;
  logic [6:0] cur_delay = '0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cur_s = {lights, delay_q, done};
      if (cur_s !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_change actual=%0h required=%0h",
                   cur_s, prev);
        end else begin
          exp_s = exp_q.pop_front();
          chk("snapshot", cur_s, exp_s);
        end
        prev = cur_s;
      end
    end
  end

  task automatic step(input bit tk);
    @(negedge clk);
    chk("lfsr_en", lfsr_en, ph != 2);
    chk("busy", busy, ph != 0);
    tick    = tk;
    abort   = 1'b0;
    rnd     = 7'($urandom);
    trigger = hold_trig | (trig_rand & 1'($urandom));
  endtask

  task automatic tick_wait();
    int g;
    g = gap_fixed ? 4 : $urandom_range(2, 5);
    repeat (g - 1) step(1'b0);
    step(1'b1);
  endtask

  // mode: 0 full, 1 abort at lights=0F, 2 abort at count 5, 3 async rst at count 5
  task automatic run_seq(input logic [6:0] r, input int mode, input bit twt);
    logic [6:0] d;
    int cnt;
    @(negedge clk);
    chk("lfsr_en_start", lfsr_en, ph != 2);
    chk("busy_start", busy, ph != 0);
    trigger = 1'b1;
    tick    = twt;
    abort   = 1'b0;
    rnd     = 7'($urandom);
    ph = 1;
    trig_rand = 1;
    for (int k = 1; k <= 8; k++) begin
      if (mode == 1 && k == 5) begin
        step(1'b0);
        abort = 1'b1;
        tick  = 1'($urandom);
        exp_q.push_back({8'h00, cur_delay, 1'b0});
        ph = 0;
        trig_rand = 0;
        step(1'b0);
        return;
      end
      tick_wait();
      exp_q.push_back({8'((1 << k) - 1), cur_delay, 1'b0});
    end
    tick_wait();
    rnd = r;
    d = (r < 7'd1) ? 7'd1 : r;
    if (d != cur_delay) exp_q.push_back({8'hFF, d, 1'b0});
    cur_delay = d;
    ph = 2;
    for (int j = 1; j <= int'(d); j++) begin
      cnt = int'(d) - j + 1;
      if (mode == 2 && cnt == 5) begin
        step(1'b0);
        abort = 1'b1;
        tick  = 1'($urandom);
        exp_q.push_back({8'h00, cur_delay, 1'b0});
        ph = 0;
        trig_rand = 0;
        step(1'b0);
        return;
      end
      if (mode == 3 && cnt == 5) begin
        step(1'b0);
        exp_q.push_back({8'h00, 7'h00, 1'b0});
        #2 rst = 1'b1;
        #1;
        chk("rst_lights", lights, 0);
        chk("rst_delay", delay_q, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lfsr_en", lfsr_en, 1);
        cur_delay = '0;
        ph = 0;
        trig_rand = 0;
        step(1'b0);
        #1 rst = 1'b0;
        step(1'b0);
        return;
      end
      tick_wait();
      if (j == int'(d)) begin
        exp_q.push_back({8'h00, d, 1'b1});
        exp_q.push_back({8'h00, d, 1'b0});
      end
    end
    ph = 0;
    trig_rand = 0;
    step(1'b0);
    if (hold_trig) ph = 1;
  endtask

  initial begin
    rst = 1'b1;
    trigger = 1'b0;
    abort = 1'b0;
    tick = 1'b0;
    rnd = '0;
    #12;
    chk("reset_lights", lights, 0);
    chk("reset_delay", delay_q, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_lfsr_en", lfsr_en, 1);
    prev = '0;
    rst = 1'b0;
    mon_en = 1;

    gap_fixed = 1;
    run_seq(7'h25, 0, 1'b0);
    gap_fixed = 0;
    run_seq(7'h00, 0, 1'b0);
    run_seq(7'($urandom_range(1, 20)), 0, 1'b1);
    run_seq(7'($urandom), 1, 1'b0);
    run_seq(7'($urandom_range(6, 40)), 2, 1'b0);
    hold_trig = 1;
    run_seq(7'($urandom_range(1, 20)), 0, 1'b0);
    hold_trig = 0;
    run_seq(7'($urandom_range(1, 20)), 0, 1'b0);
    run_seq(7'($urandom_range(6, 40)), 3, 1'b0);
    run_seq(7'($urandom_range(1, 30)), 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_seq(7'($urandom), 0, 1'($urandom));
    end
    run_seq(cur_delay, 0, 1'b0);

    repeat (5) step(1'b0);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
